// File: rtl/wash_pkg.sv
// Shared phase codes and helpers for the wash sequencer and the LCD status stage.
package wash_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_WASH = 3'd1;
  localparam logic [ST_W-1:0] ST_SPIN = 3'd2;
  localparam logic [ST_W-1:0] ST_DRY  = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE = 3'd4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE = ST_IDLE,
    S_WASH = ST_WASH,
    S_SPIN = ST_SPIN,
    S_DRY  = ST_DRY,
    S_DONE = ST_DONE
  } phase_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Per-phase cycle timer: clear on state entry, count when enabled, flag the last cycle.
module wash_phase_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [TW-1:0] limit,
  output logic [TW-1:0] count,
  output logic          expired_c
);

  // Terminal count is limit-1 so a phase spans exactly 'limit' active cycles.
  assign expired_c = (count == (limit - TW'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine sequencer IDLE->WASH->SPIN->DRY->DONE with per-phase timers.
// Optional WASH_PAUSE_EN adds a pause input that freezes the running phase.
module wash_cycle_ctrl
  import wash_pkg::*;
#(
  parameter int unsigned WASH_CYCLES = 50_000_000,
  parameter int unsigned SPIN_CYCLES = 30_000_000,
  parameter int unsigned DRY_CYCLES  = 40_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            power,
  input  logic            water_full,
  input  logic            detergent_full,
`ifdef WASH_PAUSE_EN
  input  logic            pause,
`endif
  output logic [ST_W-1:0] state,
  output logic            wash_ongoing,
  output logic            spin_ongoing,
  output logic            dry_ongoing,
  output logic            finished,
  output logic            state_chg
);

  localparam int unsigned TW = $clog2(max3(WASH_CYCLES, SPIN_CYCLES, DRY_CYCLES) + 1);

  phase_e        phase;
  phase_e        phase_nxt;
  logic [TW-1:0] limit;
  logic [TW-1:0] timer;
  logic          run;
  logic          tc;
  logic          clear;
  logic          hold;

`ifdef WASH_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // Next-state function; abort on power loss outranks a terminal count.
  function automatic phase_e next_phase(input phase_e cur, input logic pwr,
                                        input logic start, input logic step_done);
    next_phase = cur;
    case (cur)
      S_IDLE:  if (pwr && start) next_phase = S_WASH;
      S_WASH:  if (!pwr) next_phase = S_IDLE; else if (step_done) next_phase = S_SPIN;
      S_SPIN:  if (!pwr) next_phase = S_IDLE; else if (step_done) next_phase = S_DRY;
      S_DRY:   if (!pwr) next_phase = S_IDLE; else if (step_done) next_phase = S_DONE;
      S_DONE:  if (!pwr) next_phase = S_IDLE;
      default: next_phase = S_IDLE;
    endcase
  endfunction

  always_comb begin
    limit = '0;
    run   = 1'b0;
    case (phase)
      S_WASH: begin
        limit = TW'(WASH_CYCLES);
        run   = water_full & ~hold;
      end
      S_SPIN: begin
        limit = TW'(SPIN_CYCLES);
        run   = ~hold;
      end
      S_DRY: begin
        limit = TW'(DRY_CYCLES);
        run   = ~hold;
      end
      default: ;
    endcase
    phase_nxt = next_phase(phase, power, water_full & detergent_full, run & tc);
    clear     = (phase_nxt != phase);
  end

  wash_phase_timer #(.TW(TW)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .enable    (run),
    .limit     (limit),
    .count     (timer),
    .expired_c (tc)
  );

  // Flags come from the same next-state value as the state register, so they never disagree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase        <= S_IDLE;
      state_chg    <= 1'b0;
      wash_ongoing <= 1'b0;
      spin_ongoing <= 1'b0;
      dry_ongoing  <= 1'b0;
      finished     <= 1'b0;
    end else begin
      phase        <= phase_nxt;
      state_chg    <= (phase_nxt != phase);
      wash_ongoing <= (phase_nxt == S_WASH);
      spin_ongoing <= (phase_nxt == S_SPIN);
      dry_ongoing  <= (phase_nxt == S_DRY);
      finished     <= (phase_nxt == S_DONE);
    end
  end

  assign state = phase;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Bench for wash_cycle_ctrl with WASH=4, SPIN=3, DRY=2; pause cases run when WASH_PAUSE_EN is defined.
module tb_wash_cycle_ctrl;
  import wash_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       power = 1'b0;
  logic       water_full = 1'b0;
  logic       detergent_full = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] state;
  logic       wash_ongoing, spin_ongoing, dry_ongoing, finished, state_chg;

  typedef struct {
    logic       p, w, d, ps;
    logic [2:0] st;
    logic       chg;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic       chg;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  wash_cycle_ctrl #(
    .WASH_CYCLES(4),
    .SPIN_CYCLES(3),
    .DRY_CYCLES (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .power          (power),
    .water_full     (water_full),
    .detergent_full (detergent_full),
`ifdef WASH_PAUSE_EN
    .pause          (pause),
`endif
    .state          (state),
    .wash_ongoing   (wash_ongoing),
    .spin_ongoing   (spin_ongoing),
    .dry_ongoing    (dry_ongoing),
    .finished       (finished),
    .state_chg      (state_chg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("wash_ongoing", 32'(wash_ongoing), 32'(e.st == ST_WASH));
      chk("spin_ongoing", 32'(spin_ongoing), 32'(e.st == ST_SPIN));
      chk("dry_ongoing", 32'(dry_ongoing), 32'(e.st == ST_DRY));
      chk("finished", 32'(finished), 32'(e.st == ST_DONE));
      chk("state_chg", 32'(state_chg), 32'(e.chg));
    end
  endtask

  // Drive one cycle of inputs, queue what must appear after the edge, then compare.
  task automatic step(input logic p, input logic w, input logic d, input logic ps,
                      input logic [2:0] st, input logic chg);
    power = p;
    water_full = w;
    detergent_full = d;
    pause = ps;
    exp_q.push_back('{st: st, chg: chg});
    @(posedge clk);
    #1;
    check_out();
  endtask

  function automatic void add(input logic p, input logic w, input logic d, input logic ps,
                              input logic [2:0] st, input logic chg);
    vec_t v;
    v.p = p; v.w = w; v.d = d; v.ps = ps; v.st = st; v.chg = chg;
    tbl.push_back(v);
  endfunction

  initial begin
    #1;
    exp_q.push_back('{st: ST_IDLE, chg: 1'b0});
    check_out();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Full cycle, DONE hold, power-off return
    add(1, 1, 1, 0, ST_WASH, 1);
    for (int i = 0; i < 3; i++) add(1, 1, 1, 0, ST_WASH, 0);
    add(1, 1, 1, 0, ST_SPIN, 1);
    for (int i = 0; i < 2; i++) add(1, 1, 1, 0, ST_SPIN, 0);
    add(1, 1, 1, 0, ST_DRY, 1);
    add(1, 1, 1, 0, ST_DRY, 0);
    add(1, 1, 1, 0, ST_DONE, 1);
    for (int i = 0; i < 2; i++) add(1, 0, 0, 0, ST_DONE, 0);
    add(0, 1, 1, 0, ST_IDLE, 1);
    add(0, 1, 1, 0, ST_IDLE, 0);
    // Missing detergent blocks start; abort from WASH
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, ST_IDLE, 0);
    add(1, 1, 1, 0, ST_WASH, 1);
    add(0, 1, 1, 0, ST_IDLE, 1);
    add(1, 1, 0, 0, ST_IDLE, 0);
    // Water drop freezes WASH: 2 + 5 frozen + 2 cycles = 9 in WASH
    add(1, 1, 1, 0, ST_WASH, 1);
    for (int i = 0; i < 2; i++) add(1, 1, 1, 0, ST_WASH, 0);
    for (int i = 0; i < 5; i++) add(1, 0, 1, 0, ST_WASH, 0);
    add(1, 1, 1, 0, ST_WASH, 0);
    add(1, 1, 1, 0, ST_SPIN, 1);
    // Power loss on SPIN terminal cycle wins over the move to DRY
    for (int i = 0; i < 2; i++) add(1, 1, 1, 0, ST_SPIN, 0);
    add(0, 1, 1, 0, ST_IDLE, 1);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].p, tbl[i].w, tbl[i].d, tbl[i].ps, tbl[i].st, tbl[i].chg);

    chk("timer_after_abort", 32'(dut.u_timer.count), 32'd0);
    step(1, 1, 0, 0, ST_IDLE, 0);

    // Asynchronous reset in the middle of SPIN
    step(1, 1, 1, 0, ST_WASH, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, ST_WASH, 0);
    step(1, 1, 1, 0, ST_SPIN, 1);
    step(1, 1, 1, 0, ST_SPIN, 0);
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back('{st: ST_IDLE, chg: 1'b0});
    check_out();
    power = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("timer_after_reset", 32'(dut.u_timer.count), 32'd0);
    step(0, 0, 0, 0, ST_IDLE, 0);
    step(1, 1, 1, 0, ST_WASH, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, ST_WASH, 0);
    step(1, 1, 1, 0, ST_SPIN, 1);
    step(0, 1, 1, 0, ST_IDLE, 1);

`ifdef WASH_PAUSE_EN
    // Pause ignored in IDLE; 3 paused cycles stretch DRY to 5
    step(1, 1, 1, 1, ST_WASH, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, ST_WASH, 0);
    step(1, 1, 1, 0, ST_SPIN, 1);
    for (int i = 0; i < 2; i++) step(1, 1, 1, 0, ST_SPIN, 0);
    step(1, 1, 1, 0, ST_DRY, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, ST_DRY, 0);
    step(1, 1, 1, 0, ST_DRY, 0);
    step(1, 1, 1, 0, ST_DONE, 1);
    step(0, 1, 1, 0, ST_IDLE, 1);
    // Power loss while paused still aborts
    step(1, 1, 1, 0, ST_WASH, 1);
    step(1, 1, 1, 1, ST_WASH, 0);
    step(0, 1, 1, 1, ST_IDLE, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
